// File: rtl/reg_file_pkg.sv
// Shared types and constants for the integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // x0 is hardwired to zero: never written, always reads 0
    localparam addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: one writeback port and two operand read ports.
// Latency: reads combinational, writes land on the next rising clock edge.
// Backpressure: none, every write is accepted the cycle it is presented.
interface reg_file_if;
    import reg_file_pkg::*;

    logic  w_en;
    addr_t rd_addr;
    word_t w_data;
    addr_t ra_addr;
    addr_t rb_addr;
    word_t ra_value;
    word_t rb_value;

    // core side: drives writeback and read addresses, consumes operands
    modport master (
        output w_en, rd_addr, w_data, ra_addr, rb_addr,
        input  ra_value, rb_value
    );

    // register file side
    modport slave (
        input  w_en, rd_addr, w_data, ra_addr, rb_addr,
        output ra_value, rb_value
    );

endinterface

// File: rtl/reg_file_rdport.sv
// Single combinational read port: selects one entry, x0 forced to zero.
// Latency: zero, purely combinational.
// Backpressure: none.
module reg_file_rdport
    import reg_file_pkg::*;
(
    input  word_t regs [NREGS],
    input  addr_t addr,
    output word_t value
);

    // read mux; address 0 returns zero regardless of array contents
    always_comb begin
        value = '0;
        if (addr != ZERO_REG) begin
            value = regs[addr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry integer register file, 2 read ports, 1 write port, x0 hardwired to zero.
// Latency: reads combinational (old value during the writing cycle), writes visible after the edge.
// Backpressure: none; async active-high reset clears every entry and drops the pending write.
module reg_file
    import reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  rf
);

    word_t regs_q [NREGS];
    word_t regs_d [NREGS];

    // write decoder: only the addressed entry changes; x0 is kept at zero
    always_comb begin
        regs_d = regs_q;
        if (rf.w_en && (rf.rd_addr != ZERO_REG)) begin
            regs_d[rf.rd_addr] = rf.w_data;
        end
        regs_d[ZERO_REG] = '0;
    end

    // register array with asynchronous clear; a write on a reset edge is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // no write-to-read bypass: both ports look only at the stored array
    reg_file_rdport u_rdport_a (
        .regs  (regs_q),
        .addr  (rf.ra_addr),
        .value (rf.ra_value)
    );

    reg_file_rdport u_rdport_b (
        .regs  (regs_q),
        .addr  (rf.rb_addr),
        .value (rf.rb_value)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, x0, write/read timing, no bypass, async reset.
// Latency: checks sampled 1-2 time units after edges or input changes.
// Backpressure: n/a.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    reg_file_if rf ();

    reg_file u_dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic en, input addr_t rd, input word_t dat);
        rf.w_en    = en;
        rf.rd_addr = rd;
        rf.w_data  = dat;
    endtask

    task automatic set_rr(input addr_t a, input addr_t b);
        rf.ra_addr = a;
        rf.rb_addr = b;
    endtask

    // safety net in case the run stalls
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_rd(1'b0, 5'd0, 32'd0);
        set_rr(5'd0, 5'd0);

        // 1. reset held for two cycles, then reads of r1/r2/r31 return 0
        tick();
        tick();
        check("rst_ra0", rf.ra_value, 32'd0);
        check("rst_rb0", rf.rb_value, 32'd0);
        set_rr(5'd31, 5'd7);
        #1;
        check("rst_ra31", rf.ra_value, 32'd0);
        check("rst_rb7", rf.rb_value, 32'd0);
        rst = 1'b0;
        set_rr(5'd1, 5'd2);
        #1;
        check("post_rst_r1", rf.ra_value, 32'd0);
        check("post_rst_r2", rf.rb_value, 32'd0);
        set_rr(5'd31, 5'd31);
        #1;
        check("post_rst_r31", rf.ra_value, 32'd0);

        // 2. write to x0 is ignored
        set_rd(1'b1, 5'd0, 32'd400);
        set_rr(5'd0, 5'd0);
        tick();
        check("x0_ra", rf.ra_value, 32'd0);
        check("x0_rb", rf.rb_value, 32'd0);

        // 3. r1 <= 1, both ports read it next cycle
        set_rd(1'b1, 5'd1, 32'd1);
        tick();
        set_rd(1'b0, 5'd0, 32'd0);
        set_rr(5'd1, 5'd1);
        #1;
        check("r1_ra", rf.ra_value, 32'd1);
        check("r1_rb", rf.rb_value, 32'd1);

        // 4. writing r2 leaves r1 reads alone; r2 visible after the edge
        set_rd(1'b1, 5'd2, 32'd2);
        #1;
        check("w2_ra_hold", rf.ra_value, 32'd1);
        check("w2_rb_hold", rf.rb_value, 32'd1);
        tick();
        set_rd(1'b0, 5'd0, 32'd0);
        set_rr(5'd1, 5'd2);
        #1;
        check("r2_rb", rf.rb_value, 32'd2);
        check("r2_ra_r1", rf.ra_value, 32'd1);

        // 5. no bypass on r31: old value before the edge, new after; w_en=0 keeps it
        set_rd(1'b1, 5'd31, 32'd31);
        set_rr(5'd31, 5'd31);
        #1;
        check("r31_old_ra", rf.ra_value, 32'd0);
        check("r31_old_rb", rf.rb_value, 32'd0);
        tick();
        check("r31_new_ra", rf.ra_value, 32'd31);
        set_rd(1'b0, 5'd31, 32'h5555_5555);
        tick();
        check("r31_wen0", rf.ra_value, 32'd31);
        check("r31_wen0_rb", rf.rb_value, 32'd31);

        // independent ports reading different freshly written entries
        set_rd(1'b1, 5'd3, 32'hA5A5_0003);
        tick();
        set_rd(1'b1, 5'd4, 32'h0F0F_0004);
        tick();
        set_rd(1'b0, 5'd0, 32'd0);
        set_rr(5'd3, 5'd4);
        #1;
        check("r3_ra", rf.ra_value, 32'hA5A5_0003);
        check("r4_rb", rf.rb_value, 32'h0F0F_0004);

        // 6. r5 <= DEADBEEF, then async reset mid-cycle with a write pending
        set_rd(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        set_rd(1'b1, 5'd5, 32'd1234);
        set_rr(5'd5, 5'd31);
        #1;
        check("r5_before", rf.ra_value, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r5", rf.ra_value, 32'd0);
        check("async_rst_r31", rf.rb_value, 32'd0);
        // edge with rst high and w_en=1: write dropped
        tick();
        check("rst_edge_drop", rf.ra_value, 32'd0);
        #1;
        rst = 1'b0;
        set_rd(1'b0, 5'd0, 32'd0);
        set_rr(5'd5, 5'd1);
        tick();
        check("after_rst_r5", rf.ra_value, 32'd0);
        check("after_rst_r1", rf.rb_value, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
